// File: rtl/pc_redirect_unit_if.sv
// Front-end redirect bus between the pipeline control logic and the PC redirect unit.
//   Inputs to the unit : MEM_Branch/MEM_BranchTarget (taken branch resolved in MEM),
//                        ID_Jump/ID_JumpTarget (jump decoded in ID), Stall, Halt.
//   Outputs of the unit: PC (fetch address), IF/ID/EX_Flush (pipeline squash),
//                        Halted, FlushCount (saturating redirect counter, CNT_W bits).
// master: drives the requests (pipeline side); slave: the redirect unit itself.
interface pc_redirect_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             MEM_Branch;
    logic [31:0]      MEM_BranchTarget;
    logic             ID_Jump;
    logic [31:0]      ID_JumpTarget;
    logic             Stall;
    logic             Halt;
    logic [31:0]      PC;
    logic             IF_Flush;
    logic             ID_Flush;
    logic             EX_Flush;
    logic             Halted;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output MEM_Branch, MEM_BranchTarget, ID_Jump, ID_JumpTarget, Stall, Halt,
        input  PC, IF_Flush, ID_Flush, EX_Flush, Halted, FlushCount
    );

    modport slave (
        input  MEM_Branch, MEM_BranchTarget, ID_Jump, ID_JumpTarget, Stall, Halt,
        output PC, IF_Flush, ID_Flush, EX_Flush, Halted, FlushCount
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC and the RUN/HALT control state.
//   CLK   : single clock, all state on the rising edge.
//   Reset : asynchronous, active-low; forces PC=RESET_PC, RUN, FlushCount=0, flushes low.
//   bus   : pc_redirect_unit_if slave modport (redirect requests in, PC/flush/status out).
// Priority in RUN: branch > halt (unless stalled) > jump > stall > sequential PC+4.
// HALT is sticky until reset; FlushCount counts taken redirects and saturates.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input logic              CLK,
    input logic              Reset,
    pc_redirect_unit_if.slave bus
);

    typedef enum logic {StRun = 1'b0, StHalt = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_run;
    logic take_branch;
    logic take_halt;
    logic take_jump;

    // Request decode. A halt seen together with a MEM branch is on the wrong path, so it is
    // dropped; a stalled halt waits for the stall to clear. A halt beats a same-cycle jump.
    always_comb begin
        in_run      = (state_q == StRun);
        take_branch = in_run & bus.MEM_Branch;
        take_halt   = in_run & ~bus.MEM_Branch & bus.Halt & ~bus.Stall;
        take_jump   = in_run & ~bus.MEM_Branch & ~take_halt & bus.ID_Jump;
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (take_halt) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    // PC and redirect counter next values.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (take_branch) begin
            pc_d = bus.MEM_BranchTarget & ~32'h3;
        end else if (take_jump) begin
            pc_d = bus.ID_JumpTarget & ~32'h3;
        end else if (in_run && !take_halt && !bus.Stall) begin
            pc_d = pc_q + 32'd4;
        end
        if ((take_branch || take_jump) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs. Flushes are combinational from the request inputs and are held low while
    // Reset is asserted so nothing downstream is squashed by stale requests during reset.
    always_comb begin
        bus.PC         = pc_q;
        bus.FlushCount = cnt_q;
        bus.Halted     = (state_q == StHalt);
        bus.IF_Flush   = Reset & (take_branch | take_jump);
        bus.ID_Flush   = Reset & take_branch;
        bus.EX_Flush   = Reset & take_branch;
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: three instances (default, RESET_PC=0xFFFF_FFFC, CNT_W=2) share
// one stimulus stream and are compared against a behavioural model every cycle.
module tb_pc_redirect_unit;

    logic CLK;
    logic Reset;

    logic        in_br, in_j, in_st, in_h;
    logic [31:0] in_bt, in_jt;

    pc_redirect_unit_if #(.CNT_W(16)) bus0 ();
    pc_redirect_unit_if #(.CNT_W(16)) bus1 ();
    pc_redirect_unit_if #(.CNT_W(2))  bus2 ();

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut0 (
        .CLK(CLK), .Reset(Reset), .bus(bus0.slave)
    );
    pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut1 (
        .CLK(CLK), .Reset(Reset), .bus(bus1.slave)
    );
    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .bus(bus2.slave)
    );

    assign bus0.MEM_Branch = in_br;  assign bus0.MEM_BranchTarget = in_bt;
    assign bus0.ID_Jump    = in_j;   assign bus0.ID_JumpTarget    = in_jt;
    assign bus0.Stall      = in_st;  assign bus0.Halt             = in_h;
    assign bus1.MEM_Branch = in_br;  assign bus1.MEM_BranchTarget = in_bt;
    assign bus1.ID_Jump    = in_j;   assign bus1.ID_JumpTarget    = in_jt;
    assign bus1.Stall      = in_st;  assign bus1.Halt             = in_h;
    assign bus2.MEM_Branch = in_br;  assign bus2.MEM_BranchTarget = in_bt;
    assign bus2.ID_Jump    = in_j;   assign bus2.ID_JumpTarget    = in_jt;
    assign bus2.Stall      = in_st;  assign bus2.Halt             = in_h;

    logic [31:0] o_pc[3];
    logic [15:0] o_cnt[3];
    logic [2:0]  o_fl[3];
    logic        o_halted[3];

    assign o_pc[0] = bus0.PC;
    assign o_pc[1] = bus1.PC;
    assign o_pc[2] = bus2.PC;
    assign o_cnt[0] = bus0.FlushCount;
    assign o_cnt[1] = bus1.FlushCount;
    assign o_cnt[2] = 16'(bus2.FlushCount);
    assign o_fl[0] = {bus0.IF_Flush, bus0.ID_Flush, bus0.EX_Flush};
    assign o_fl[1] = {bus1.IF_Flush, bus1.ID_Flush, bus1.EX_Flush};
    assign o_fl[2] = {bus2.IF_Flush, bus2.ID_Flush, bus2.EX_Flush};
    assign o_halted[0] = bus0.Halted;
    assign o_halted[1] = bus1.Halted;
    assign o_halted[2] = bus2.Halted;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: architectural state per instance.
    logic [31:0] m_pc[3];
    bit          m_halt[3];
    int          m_cnt[3];
    logic [31:0] reset_pc[3];
    int          cnt_max[3];

    int n_checks;
    int n_err;
    int step_no;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s step %0d: observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i]   = reset_pc[i];
            m_halt[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    // One clock edge of the architectural behaviour, from the current inputs.
    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_halt[i]) begin
                    if (in_br) begin
                        m_pc[i] = {in_bt[31:2], 2'b00};
                        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                    end else if (in_h && !in_st) begin
                        m_halt[i] = 1'b1;
                    end else if (in_j) begin
                        m_pc[i] = {in_jt[31:2], 2'b00};
                        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                    end else if (!in_st) begin
                        m_pc[i] = m_pc[i] + 32'd4;
                    end
                end
            end
        end
    endtask

    function automatic logic [2:0] exp_flush(input int i);
        if (!Reset || m_halt[i])  return 3'b000;
        if (in_br)                return 3'b111;
        if (in_h && !in_st)       return 3'b000;
        if (in_j)                 return 3'b100;
        return 3'b000;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_u%0d_pc", tag, i), o_pc[i], m_pc[i]);
            check($sformatf("%s_u%0d_halted", tag, i), 32'(o_halted[i]), 32'(m_halt[i]));
            check($sformatf("%s_u%0d_cnt", tag, i), 32'(o_cnt[i]), 32'(m_cnt[i]));
            check($sformatf("%s_u%0d_flush", tag, i), 32'(o_fl[i]), 32'(exp_flush(i)));
        end
    endtask

    task automatic step(input logic br, input logic [31:0] bt, input logic j,
                        input logic [31:0] jt, input logic st, input logic h);
        @(negedge CLK);
        step_no++;
        in_br = br; in_bt = bt; in_j = j; in_jt = jt; in_st = st; in_h = h;
        #1 check_all("step");
        @(posedge CLK);
        model_edge();
    endtask

    // Reset pulse placed between edges; outputs must already show reset values.
    task automatic reset_pulse();
        @(negedge CLK);
        step_no++;
        in_br = 1'b0; in_j = 1'b0; in_st = 1'b0; in_h = 1'b0;
        #2 Reset = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 Reset = 1'b1;
        @(posedge CLK);
        model_edge();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        step_no  = 0;
        reset_pc[0] = 32'h0000_0000; cnt_max[0] = 65535;
        reset_pc[1] = 32'hFFFF_FFFC; cnt_max[1] = 65535;
        reset_pc[2] = 32'h0000_0000; cnt_max[2] = 3;
        Reset = 1'b0;
        in_br = 1'b0; in_bt = '0; in_j = 1'b0; in_jt = '0; in_st = 1'b0; in_h = 1'b0;
        model_reset();

        // Held in reset across edges.
        repeat (2) @(negedge CLK);
        #1 check_all("reset");
        check("reset_pc_lit", o_pc[0], 32'h0);
        check("reset_wrap_pc_lit", o_pc[1], 32'hFFFF_FFFC);
        #1 Reset = 1'b1;
        @(posedge CLK);
        model_edge();

        // Sequential fetch; the wrap instance rolls 0xFFFF_FFFC -> 0.
        repeat (3) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("seq_pc_lit", o_pc[0], 32'h10);
        check("wrap_pc_lit", o_pc[1], 32'hC);

        // Branch beats stall.
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        #1 check("br_stall_pc_lit", o_pc[0], 32'h40);
        check("br_stall_cnt_lit", 32'(o_cnt[0]), 32'd1);

        // Branch beats jump, counted once.
        step(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
        #1 check("br_jmp_pc_lit", o_pc[0], 32'h80);
        check("br_jmp_cnt_lit", 32'(o_cnt[0]), 32'd2);

        // Jump alone, low bits of target dropped.
        step(1'b0, 32'h0, 1'b1, 32'h203, 1'b0, 1'b0);
        #1 check("jmp_pc_lit", o_pc[0], 32'h200);

        // Halt under a branch is wrong-path; the 2-bit counter saturates here.
        step(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("halt_br_pc_lit", o_pc[0], 32'h20);
        check("sat_cnt_lit", 32'(o_cnt[2]), 32'd3);

        // Stalled halt is deferred, then taken.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(k[0], 32'h300, ~k[0], 32'h400, 1'b0, 1'b0);
        end
        #1 check("halt_pc_lit", o_pc[0], 32'h20);
        check("halt_flag_lit", 32'(o_halted[0]), 32'd1);

        // Async reset out of HALT, then redirects past the small counter's limit.
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(k * 16), 1'b0, 1'b0);
        end
        #1 check("sat5_cnt_lit", 32'(o_cnt[2]), 32'd3);
        check("cnt5_lit", 32'(o_cnt[0]), 32'd5);

        // Randomized traffic with occasional reset pulses.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(39) == 0) begin
                reset_pulse();
            end else begin
                step(($urandom_range(7) == 0), $urandom(), ($urandom_range(5) == 0), $urandom(),
                     ($urandom_range(3) == 0), ($urandom_range(29) == 0));
            end
        end

        @(negedge CLK);
        #1 check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
